pulp_pwr_domain_ctrl: RTL and testbench
=======================================

// Module: pulp_pwr_domain_ctrl
// PURPOSE
// - Sequencer that drives the power cells of one switchable domain: clock gate, isolation, clamp, domain reset, switch sleep.
// - Lives in the always-on domain and sits above the power-gating switch chain, isolation cells and clamping level shifters.
// - Turns a level request from the PMU or SoC control into an ordered, handshaked power-down or power-up sequence.
// PARAMETERS
// - CLK_CYC      4     cycles between clock gate and isolation (down), or de-isolation and clock enable (up)
// - ISO_CYC      2     cycles isolation/clamp settles before domain reset asserts (down) or after it releases (up)
// - SETTLE_CYC   16    cycles after sleepout_i falls before restore/reset release
// - ACK_TIMEOUT  1024  max cycles waiting on sleepout_i; must be > SETTLE_CYC
// - RST_ON       1     1: controller leaves reset in ON; 0: in OFF
// PORTS
// - clk_i          in   1  always-on clock
// - rst_i          in   1  reset, synchronous, active-high
// - pwr_req_i      in   1  level request: 1 = domain on, 0 = domain off
// - pwr_on_o       out  1  1 only in state ON
// - busy_o         out  1  1 in any state other than ON/OFF
// - err_o          out  1  sticky: an ack timeout occurred; cleared only by rst_i
// - clk_en_o       out  1  domain clock-gate enable
// - iso_ena_o      out  1  isolation-cell enable (1 = pass data, 0 = isolated/forced)
// - clamp_o        out  1  clamp input of the clamping level shifters (1 = clamp to 0)
// - dom_rst_o      out  1  domain reset, active-high
// - sleep_o        out  1  to switch chain sleep input (1 = switches off)
// - sleepout_i     in   1  switch chain sleepout (the delayed sleep), used as ack
// - state_o        out  4  current FSM state encoding (debug)
// BEHAVIOUR
// - All outputs are registered. Reset values:
//   RST_ON=1: clk_en=1, iso_ena=1, clamp=0, dom_rst=0, sleep=0, state=ON.
//   RST_ON=0: clk_en=0, iso_ena=0, clamp=1, dom_rst=1, sleep=1, state=OFF.
//   Both cases: err=0, busy=0.
// - States:
//   ON, CLK_OFF, ISOLATE, [SAVE], RST_ON_S, SLEEP, OFF, WAKE, SETTLE, [RESTORE], RST_REL, DEISO, CLK_ON.
// - Down sequence, entered from ON when pwr_req_i=0:
//   - CLK_OFF: clk_en=0; wait CLK_CYC.
//   - ISOLATE: iso_ena=0, clamp=1; wait ISO_CYC.
//   - SAVE (optional, see CONFIGURATION).
//   - RST_ON_S: dom_rst=1 for 1 cycle.
//   - SLEEP: sleep=1; wait sleepout_i=1 or timeout.
//   - OFF.
// - Up sequence, entered from OFF when pwr_req_i=1:
//   - WAKE: sleep=0; wait sleepout_i=0 or timeout.
//   - SETTLE: wait SETTLE_CYC.
//   - RESTORE (optional).
//   - RST_REL: dom_rst=0; wait ISO_CYC.
//   - DEISO: iso_ena=1, clamp=0; wait CLK_CYC.
//   - CLK_ON: clk_en=1 for 1 cycle.
//   - ON.
// - Each wait of N cycles occupies exactly N cycles in that state, counted from entry. A single shared down-counter, width $clog2(ACK_TIMEOUT+1), is reloaded on every state change.
// - Ack timeout: when ACK_TIMEOUT cycles elapse in SLEEP or WAKE, set err_o and advance as if acked.
// - pwr_req_i is sampled only in ON and OFF. A request change mid-sequence is ignored until the sequence completes, then honoured from the terminal state; no abort or reversal.
// - pwr_on_o=1 implies clk_en=1, iso_ena=1, clamp=0, dom_rst=0, sleep=0.
// - sleepout_i already at the target level on entry to SLEEP/WAKE: advance the next cycle.
// - sleepout_i toggling in ON/OFF: ignored.
// - rst_i mid-sequence: jump to the reset state with reset outputs on the next edge. The integrator must make sure RST_ON matches the physical domain state after reset.
// CONFIGURATION
// - PULP_PWR_RETENTION_EN defined:
//   - Adds SAVE after ISOLATE and RESTORE after SETTLE.
//   - Adds ports ret_save_o, ret_restore_o (out, 1) and ret_ack_i (in, 1).
//   - Each request is held high until ret_ack_i=1, then dropped; the FSM advances the cycle after the ack. Same ACK_TIMEOUT and err_o rule applies.
//   - ret_save_o and ret_restore_o reset to 0.
// - Not defined: these states and ports do not exist; ISOLATE goes directly to RST_ON_S, and SETTLE goes directly to RST_REL.
// STRUCTURE
// - Package pulp_pwr_pkg holds:
//   - typedef pwr_state_e, a 4-bit enum of the states above; the encoding is fixed even when retention states are unused.
//   - Default constants for the timing parameters.
// - One sub-module, pulp_pwr_wait_cnt: loadable down-counter with a zero flag, used for every wait/timeout.
// - The FSM and output registers live in the top.
// TESTING
// - RST_ON=1, reset, pwr_req_i=0:
//   - clk_en falls at cycle 1, iso_ena falls at cycle 5, dom_rst pulses at cycle 7, then sleep=1.
//   - Drive sleepout_i=1 three cycles later -> state OFF, busy=0.
// - From OFF, pwr_req_i=1, sleepout_i falls after 5 cycles:
//   - SETTLE lasts 16 cycles, then dom_rst=0.
//   - iso_ena=1 two cycles later, clk_en=1 four cycles after that -> pwr_on_o=1.
// - Hold sleepout_i=0 in SLEEP:
//   - err_o=1 after exactly 1024 cycles and the FSM reaches OFF.
//   - err_o stays 1 through a later full up-sequence.
// - Toggle pwr_req_i 0 -> 1 during ISOLATE:
//   - The down-sequence completes to OFF, then an up-sequence starts immediately without waiting for a new edge.
// - Assert rst_i during WAKE with RST_ON=0:
//   - Next cycle sleep=1, clamp=1, iso_ena=0, state=OFF, err_o=0.
// - With PULP_PWR_RETENTION_EN: ret_save_o is held until ret_ack_i=1 (ack delayed 7 cycles), RST_ON_S is entered 1 cycle after the ack, and the ordering of all other outputs is unchanged.

Source files
------------

// File: rtl/pulp_pwr_pkg.sv
// Shared types and default timing constants for the power-domain sequencer.
// The state encoding is fixed whether or not PULP_PWR_RETENTION_EN is defined,
// so debug tooling can decode state_o the same way in every build.
package pulp_pwr_pkg;

  localparam int DEF_CLK_CYC     = 4;
  localparam int DEF_ISO_CYC     = 2;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_ACK_TIMEOUT = 1024;
  localparam bit DEF_RST_ON      = 1'b1;

  typedef enum logic [3:0] {
    ST_ON      = 4'd0,
    ST_CLK_OFF = 4'd1,
    ST_ISOLATE = 4'd2,
    ST_SAVE    = 4'd3,
    ST_RST_ON  = 4'd4,
    ST_SLEEP   = 4'd5,
    ST_OFF     = 4'd6,
    ST_WAKE    = 4'd7,
    ST_SETTLE  = 4'd8,
    ST_RESTORE = 4'd9,
    ST_RST_REL = 4'd10,
    ST_DEISO   = 4'd11,
    ST_CLK_ON  = 4'd12
  } pwr_state_e;

  // Power-cell controls that are a pure function of the FSM state
  typedef struct packed {
    logic clk_en;
    logic iso_ena;
    logic clamp;
    logic dom_rst;
    logic sleep;
  } pwr_out_t;

  // Power-cell control levels held while the FSM sits in state s
  function automatic pwr_out_t pwr_out_decode(pwr_state_e s);
    pwr_out_t o;
    o.clk_en  = (s == ST_ON) || (s == ST_CLK_ON);
    o.iso_ena = (s == ST_ON) || (s == ST_CLK_OFF) || (s == ST_DEISO) || (s == ST_CLK_ON);
    o.clamp   = !o.iso_ena;
    o.dom_rst = (s == ST_RST_ON) || (s == ST_SLEEP) || (s == ST_OFF) ||
                (s == ST_WAKE) || (s == ST_SETTLE) || (s == ST_RESTORE);
    o.sleep   = (s == ST_SLEEP) || (s == ST_OFF);
    return o;
  endfunction

endpackage

// File: rtl/pulp_pwr_wait_cnt.sv
// Loadable down-counter with a zero flag. Loaded with N-1 on state entry, it
// reads zero during the Nth cycle in the state, which is when the FSM leaves.
module pulp_pwr_wait_cnt #(
  parameter int W = 11
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Reload on request, otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulp_pwr_domain_ctrl.sv
// Power-domain sequencer: orders clock gate, isolation/clamp, domain reset and
// switch-chain sleep on power-down and power-up of one switchable domain.
// Optional retention save/restore handshake: define PULP_PWR_RETENTION_EN.
//
// Handshakes: pwr_req_i is a level sampled only in ON/OFF; sleepout_i (and
// ret_ack_i) are level acks, accepted on any edge in the waiting state, and
// a missing ack is replaced by a timeout that sets the sticky err_o.
module pulp_pwr_domain_ctrl
  import pulp_pwr_pkg::*;
#(
  parameter int CLK_CYC     = DEF_CLK_CYC,
  parameter int ISO_CYC     = DEF_ISO_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter bit RST_ON      = DEF_RST_ON
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pwr_req_i,
  output logic       pwr_on_o,
  output logic       busy_o,
  output logic       err_o,
  output logic       clk_en_o,
  output logic       iso_ena_o,
  output logic       clamp_o,
  output logic       dom_rst_o,
  output logic       sleep_o,
  input  logic       sleepout_i,
`ifdef PULP_PWR_RETENTION_EN
  output logic       ret_save_o,
  output logic       ret_restore_o,
  input  logic       ret_ack_i,
`endif
  output logic [3:0] state_o
);

  localparam int         CW        = $clog2(ACK_TIMEOUT + 1);
  localparam pwr_state_e RST_STATE = RST_ON ? ST_ON : ST_OFF;

  pwr_state_e state_d, state_q;
  pwr_out_t   out_d, out_q;
  logic       err_d, err_q;
  logic       busy_d, busy_q;
  logic       pwr_on_d, pwr_on_q;
  logic       cnt_load, cnt_zero;
  logic [CW-1:0] cnt_val;
`ifdef PULP_PWR_RETENTION_EN
  logic       ret_save_d, ret_save_q;
  logic       ret_restore_d, ret_restore_q;
`endif

  // Next-state logic; timeouts advance as if acked but flag err
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_ON:      if (!pwr_req_i) state_d = ST_CLK_OFF;
      ST_CLK_OFF: if (cnt_zero) state_d = ST_ISOLATE;
`ifdef PULP_PWR_RETENTION_EN
      ST_ISOLATE: if (cnt_zero) state_d = ST_SAVE;
      ST_SAVE: begin
        if (ret_ack_i) begin
          state_d = ST_RST_ON;
        end else if (cnt_zero) begin
          state_d = ST_RST_ON;
          err_d   = 1'b1;
        end
      end
`else
      ST_ISOLATE: if (cnt_zero) state_d = ST_RST_ON;
`endif
      ST_RST_ON:  state_d = ST_SLEEP;
      ST_SLEEP: begin
        if (sleepout_i) begin
          state_d = ST_OFF;
        end else if (cnt_zero) begin
          state_d = ST_OFF;
          err_d   = 1'b1;
        end
      end
      ST_OFF:     if (pwr_req_i) state_d = ST_WAKE;
      ST_WAKE: begin
        if (!sleepout_i) begin
          state_d = ST_SETTLE;
        end else if (cnt_zero) begin
          state_d = ST_SETTLE;
          err_d   = 1'b1;
        end
      end
`ifdef PULP_PWR_RETENTION_EN
      ST_SETTLE:  if (cnt_zero) state_d = ST_RESTORE;
      ST_RESTORE: begin
        if (ret_ack_i) begin
          state_d = ST_RST_REL;
        end else if (cnt_zero) begin
          state_d = ST_RST_REL;
          err_d   = 1'b1;
        end
      end
`else
      ST_SETTLE:  if (cnt_zero) state_d = ST_RST_REL;
`endif
      ST_RST_REL: if (cnt_zero) state_d = ST_DEISO;
      ST_DEISO:   if (cnt_zero) state_d = ST_CLK_ON;
      ST_CLK_ON:  state_d = ST_ON;
      default:    state_d = RST_STATE;
    endcase
  end

  // Wait length for the state being entered; reloaded on every state change
  always_comb begin
    cnt_val = '0;
    case (state_d)
      ST_CLK_OFF, ST_DEISO:           cnt_val = CW'(CLK_CYC - 1);
      ST_ISOLATE, ST_RST_REL:         cnt_val = CW'(ISO_CYC - 1);
      ST_SETTLE:                      cnt_val = CW'(SETTLE_CYC - 1);
      ST_SLEEP, ST_WAKE,
      ST_SAVE, ST_RESTORE:            cnt_val = CW'(ACK_TIMEOUT - 1);
      default:                        cnt_val = '0;
    endcase
    cnt_load = (state_d != state_q);
  end

  // Registered outputs follow the state being entered
  always_comb begin
    out_d    = pwr_out_decode(state_d);
    pwr_on_d = (state_d == ST_ON);
    busy_d   = (state_d != ST_ON) && (state_d != ST_OFF);
`ifdef PULP_PWR_RETENTION_EN
    ret_save_d    = (state_d == ST_SAVE);
    ret_restore_d = (state_d == ST_RESTORE);
`endif
  end

  // FSM state and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= RST_STATE;
      out_q         <= pwr_out_decode(RST_STATE);
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      pwr_on_q      <= RST_ON;
`ifdef PULP_PWR_RETENTION_EN
      ret_save_q    <= 1'b0;
      ret_restore_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      pwr_on_q      <= pwr_on_d;
`ifdef PULP_PWR_RETENTION_EN
      ret_save_q    <= ret_save_d;
      ret_restore_q <= ret_restore_d;
`endif
    end
  end

  pulp_pwr_wait_cnt #(
    .W (CW)
  ) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign pwr_on_o  = pwr_on_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;
  assign clk_en_o  = out_q.clk_en;
  assign iso_ena_o = out_q.iso_ena;
  assign clamp_o   = out_q.clamp;
  assign dom_rst_o = out_q.dom_rst;
  assign sleep_o   = out_q.sleep;
  assign state_o   = state_q;
`ifdef PULP_PWR_RETENTION_EN
  assign ret_save_o    = ret_save_q;
  assign ret_restore_o = ret_restore_q;
`endif

endmodule

// File: tb/tb_pulp_pwr_domain_ctrl.sv
// Directed bench for pulp_pwr_domain_ctrl: dut_a resets into ON, dut_b into OFF.
module tb_pulp_pwr_domain_ctrl;
  import pulp_pwr_pkg::*;

`ifdef PULP_PWR_RETENTION_EN
  localparam int RET_EXTRA = 1;
`else
  localparam int RET_EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, req_a = 1'b1, so_a = 1'b0;
  logic rst_b = 1'b1, req_b = 1'b0, so_b = 1'b1;
  logic pwr_on_a, busy_a, err_a, clk_en_a, iso_a, clamp_a, drst_a, sleep_a;
  logic pwr_on_b, busy_b, err_b, clk_en_b, iso_b, clamp_b, drst_b, sleep_b;
  logic [3:0] state_a, state_b;
`ifdef PULP_PWR_RETENTION_EN
  logic ret_save_a, ret_restore_a, ret_ack_a = 1'b1;
  logic ret_save_b, ret_restore_b;
`endif

  pulp_pwr_domain_ctrl #(.RST_ON(1'b1)) dut_a (
    .clk_i (clk), .rst_i (rst_a), .pwr_req_i (req_a),
    .pwr_on_o (pwr_on_a), .busy_o (busy_a), .err_o (err_a),
    .clk_en_o (clk_en_a), .iso_ena_o (iso_a), .clamp_o (clamp_a),
    .dom_rst_o (drst_a), .sleep_o (sleep_a), .sleepout_i (so_a),
`ifdef PULP_PWR_RETENTION_EN
    .ret_save_o (ret_save_a), .ret_restore_o (ret_restore_a), .ret_ack_i (ret_ack_a),
`endif
    .state_o (state_a)
  );

  pulp_pwr_domain_ctrl #(.RST_ON(1'b0)) dut_b (
    .clk_i (clk), .rst_i (rst_b), .pwr_req_i (req_b),
    .pwr_on_o (pwr_on_b), .busy_o (busy_b), .err_o (err_b),
    .clk_en_o (clk_en_b), .iso_ena_o (iso_b), .clamp_o (clamp_b),
    .dom_rst_o (drst_b), .sleep_o (sleep_b), .sleepout_i (so_b),
`ifdef PULP_PWR_RETENTION_EN
    .ret_save_o (ret_save_b), .ret_restore_o (ret_restore_b), .ret_ack_i (1'b1),
`endif
    .state_o (state_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input pwr_state_e s, input int budget, input string tag);
    int n = 0;
    while (state_a !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, state_a, s);
  endtask

  task automatic wait_b(input pwr_state_e s, input int budget, input string tag);
    int n = 0;
    while (state_b !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, state_b, s);
  endtask

  logic h_clk[0:16], h_iso[0:16], h_rst[0:16], h_sleep[0:16];

  initial begin
    // ---- reset state, RST_ON=1 ----
    repeat (3) tick();
    check("a_rst_state", state_a, ST_ON);
    check("a_rst_pwr_on", pwr_on_a, 1);
    check("a_rst_clk_en", clk_en_a, 1);
    check("a_rst_iso", iso_a, 1);
    check("a_rst_clamp", clamp_a, 0);
    check("a_rst_dom_rst", drst_a, 0);
    check("a_rst_sleep", sleep_a, 0);
    check("a_rst_err", err_a, 0);
    check("a_rst_busy", busy_a, 0);

    // ---- down sequence, cycle-by-cycle ----
    rst_a = 1'b0;
    req_a = 1'b0;
    repeat (4) exp_q.push_back(ST_CLK_OFF);
    repeat (2) exp_q.push_back(ST_ISOLATE);
    repeat (RET_EXTRA) exp_q.push_back(ST_SAVE);
    exp_q.push_back(ST_RST_ON);
    exp_q.push_back(ST_SLEEP);
    for (int c = 1; c <= 8 + RET_EXTRA; c++) begin
      tick();
      check($sformatf("down_state_c%0d", c), state_a, exp_q.pop_front());
      h_clk[c] = clk_en_a; h_iso[c] = iso_a; h_rst[c] = drst_a; h_sleep[c] = sleep_a;
    end
    check("down_clk_en_c1", h_clk[1], 0);
    check("down_iso_c4", h_iso[4], 1);
    check("down_iso_c5", h_iso[5], 0);
    check("down_rst_before", h_rst[6 + RET_EXTRA], 0);
    check("down_rst_pulse", h_rst[7 + RET_EXTRA], 1);
    check("down_sleep_before", h_sleep[7 + RET_EXTRA], 0);
    check("down_sleep_set", h_sleep[8 + RET_EXTRA], 1);
    check("down_busy", busy_a, 1);
    repeat (3) tick();
    check("sleep_wait_state", state_a, ST_SLEEP);
    so_a = 1'b1;
    tick();
    check("off_state", state_a, ST_OFF);
    check("off_busy", busy_a, 0);
    check("off_pwr_on", pwr_on_a, 0);
    check("off_err", err_a, 0);

    // ---- up sequence ----
    req_a = 1'b1;
    tick();
    check("wake_state", state_a, ST_WAKE);
    check("wake_sleep", sleep_a, 0);
    repeat (4) tick();
    check("wake_hold", state_a, ST_WAKE);
    so_a = 1'b0;
    tick();
    check("settle_entry", state_a, ST_SETTLE);
    check("settle_dom_rst", drst_a, 1);
    repeat (15) tick();
    check("settle_last", state_a, ST_SETTLE);
    repeat (RET_EXTRA) tick();
    tick();
    check("rst_rel_state", state_a, ST_RST_REL);
    check("rst_rel_dom_rst", drst_a, 0);
    check("rst_rel_iso", iso_a, 0);
    tick();
    check("rst_rel_iso2", iso_a, 0);
    tick();
    check("deiso_iso", iso_a, 1);
    check("deiso_clamp", clamp_a, 0);
    check("deiso_clk_en", clk_en_a, 0);
    repeat (3) tick();
    check("deiso_clk_en_late", clk_en_a, 0);
    tick();
    check("clk_on_clk_en", clk_en_a, 1);
    check("clk_on_pwr_on", pwr_on_a, 0);
    tick();
    check("up_pwr_on", pwr_on_a, 1);
    check("up_busy", busy_a, 0);
    check("up_state", state_a, ST_ON);

    // ---- ack timeout in SLEEP ----
    req_a = 1'b0;
    wait_a(ST_SLEEP, 20, "to_reach_sleep");
    repeat (1023) tick();
    check("to_err_before", err_a, 0);
    check("to_state_before", state_a, ST_SLEEP);
    tick();
    check("to_err_set", err_a, 1);
    check("to_state_off", state_a, ST_OFF);
    req_a = 1'b1;
    tick();
    check("to_wake", state_a, ST_WAKE);
    tick();
    check("to_wake_fast", state_a, ST_SETTLE);
    wait_a(ST_ON, 60, "to_back_on");
    check("to_err_sticky", err_a, 1);
    check("to_pwr_on", pwr_on_a, 1);

    // ---- request flip during ISOLATE ----
    req_a = 1'b0;
    wait_a(ST_ISOLATE, 10, "flip_isolate");
    req_a = 1'b1;
    so_a  = 1'b1;
    wait_a(ST_OFF, 20, "flip_reach_off");
    check("flip_off_busy", busy_a, 0);
    tick();
    check("flip_auto_wake", state_a, ST_WAKE);
    so_a = 1'b0;
    wait_a(ST_ON, 60, "flip_back_on");

`ifdef PULP_PWR_RETENTION_EN
    // ---- retention save handshake ----
    ret_ack_a = 1'b0;
    req_a = 1'b0;
    wait_a(ST_SAVE, 20, "ret_reach_save");
    check("ret_save_hi", ret_save_a, 1);
    check("ret_save_iso", iso_a, 0);
    check("ret_save_rst", drst_a, 0);
    repeat (6) tick();
    check("ret_save_held", ret_save_a, 1);
    check("ret_save_state", state_a, ST_SAVE);
    ret_ack_a = 1'b1;
    tick();
    check("ret_rst_on", state_a, ST_RST_ON);
    check("ret_save_drop", ret_save_a, 0);
    check("ret_dom_rst", drst_a, 1);
    so_a = 1'b1;
    wait_a(ST_OFF, 20, "ret_reach_off");
`endif

    // ---- RST_ON=0: reset state, then reset during WAKE ----
    check("b_rst_state", state_b, ST_OFF);
    check("b_rst_sleep", sleep_b, 1);
    check("b_rst_clamp", clamp_b, 1);
    check("b_rst_iso", iso_b, 0);
    check("b_rst_clk_en", clk_en_b, 0);
    check("b_rst_dom_rst", drst_b, 1);
    check("b_rst_pwr_on", pwr_on_b, 0);
    rst_b = 1'b0;
    req_b = 1'b1;
    wait_b(ST_WAKE, 5, "b_wake");
    repeat (1024) tick();
    check("b_wake_timeout_err", err_b, 1);
    wait_b(ST_ON, 60, "b_on");
    req_b = 1'b0;
    wait_b(ST_OFF, 30, "b_off");
    req_b = 1'b1;
    tick();
    repeat (2) tick();
    check("b_wake_again", state_b, ST_WAKE);
    check("b_wake_err", err_b, 1);
    rst_b = 1'b1;
    tick();
    check("b_mid_rst_state", state_b, ST_OFF);
    check("b_mid_rst_sleep", sleep_b, 1);
    check("b_mid_rst_clamp", clamp_b, 1);
    check("b_mid_rst_iso", iso_b, 0);
    check("b_mid_rst_err", err_b, 0);
    check("b_mid_rst_busy", busy_b, 0);

    // ---- report ----
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
